// File: rtl/divide.sv
// Sequential unsigned restoring divider: dividend loaded into B on reset, divisor from SW at Run.
// Quotient ends in B, remainder in A, X flags a zero divisor; A/B also drive four hex displays.
module divide #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_Load_Clear,
  input  logic [WIDTH-1:0] SW,
  input  logic             Run,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             Done,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a, a_next;
  logic [WIDTH-1:0] b, b_next;
  logic [WIDTH-1:0] d, d_next;
  logic             x, x_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH:0]   trial;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can hold a value (no latches).
    state_next = state;
    a_next     = a;
    b_next     = b;
    d_next     = d;
    x_next     = x;
    count_next = count;
    // Trial subtraction of the divisor from the partial remainder with the next dividend bit shifted in.
    trial      = {a, b[WIDTH-1]} - {1'b0, d};

    case (state)
      IDLE: begin
        if (!Run) begin
          if (SW != '0) begin
            d_next     = SW;
            a_next     = '0;
            x_next     = 1'b0;
            count_next = '0;
            state_next = ITER;
          end else begin
            // Zero divisor: quotient saturates, remainder keeps the dividend.
            b_next     = '1;
            a_next     = b;
            x_next     = 1'b1;
            state_next = DONE;
          end
        end
      end
      ITER: begin
        if (!trial[WIDTH]) begin
          a_next = trial[WIDTH-1:0];
          b_next = {b[WIDTH-2:0], 1'b1};
        end else begin
          a_next = {a[WIDTH-2:0], b[WIDTH-1]};
          b_next = {b[WIDTH-2:0], 1'b0};
        end
        count_next = count + CW'(1);
        if (count == CW'(WIDTH - 1)) state_next = DONE;
      end
      DONE: begin
        if (Run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!Reset_Load_Clear) begin
      state <= IDLE;
      a     <= '0;
      b     <= SW;
      d     <= '0;
      x     <= 1'b0;
      count <= '0;
    end else begin
      state <= state_next;
      a     <= a_next;
      b     <= b_next;
      d     <= d_next;
      x     <= x_next;
      count <= count_next;
    end
  end

  assign Aval = a;
  assign Bval = b;
  assign Xval = x;
  assign Done = (state == DONE);

  assign HEX0 = seg7(a[3:0]);
  assign HEX1 = seg7(a[7:4]);
  assign HEX2 = seg7(b[3:0]);
  assign HEX3 = seg7(b[7:4]);

endmodule

// File: doc/divide.md
Name: divide

Overview:
- Sequential 8-bit unsigned restoring divider, the inverse operation of the team's shift-add multiplier.
- Uses the same board-level interface: SW input, Run pushbutton, Reset_Load_Clear pushbutton, A/B/X registers, four hex displays.
- Dividend is loaded into B via Reset_Load_Clear; divisor is taken from SW at Run.
- Result: quotient in B, remainder in A, divide-by-zero flag in X. Sits at top level on the DE-series board next to the multiplier.

Parameters:
WIDTH, 8, operand width; HEX0-HEX3 always display bits [7:0] of Aval/Bval.

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset_Load_Clear  input  1  synchronous, active-low reset; also loads dividend from SW
SW  input  WIDTH  dividend while Reset_Load_Clear low; divisor when Run is accepted
Run  input  1  active-low start pushbutton, level-sampled
Aval  output  WIDTH  A register: partial, then final, remainder
Bval  output  WIDTH  B register: dividend, then partial, then final, quotient
Xval  output  1  divide-by-zero flag
Done  output  1  high in DONE state
HEX0  output  7  active-low 7-seg of Aval[3:0]
HEX1  output  7  active-low 7-seg of Aval[7:4]
HEX2  output  7  active-low 7-seg of Bval[3:0]
HEX3  output  7  active-low 7-seg of Bval[7:4]

Behaviour:
- Reset (Reset_Load_Clear low at a rising edge; overrides everything, including mid-operation):
  - A=0, B=SW, X=0, D=0, count=0, state=IDLE, Done=0.
- Internal registers: D (WIDTH) divisor; count (3 bits for WIDTH=8, clog2(WIDTH) in general); state.
- IDLE:
  - Run high: hold all registers.
  - Run low and SW!=0: D<=SW, A<=0, X<=0, count<=0, state<=ITER.
  - Run low and SW==0: B<=all ones, A<=B (remainder = dividend), X<=1, state<=DONE.
- ITER, one restoring step per clock:
  - T = {A, B[WIDTH-1]} - {1'b0, D}, computed at WIDTH+1 bits.
  - T sign bit 0: A<=T[WIDTH-1:0], B<={B[WIDTH-2:0],1}.
  - T sign bit 1: A<={A[WIDTH-2:0],B[WIDTH-1]}, B<={B[WIDTH-2:0],0}.
  - count<=count+1. After the WIDTH-th step (count==WIDTH-1 at the edge), state<=DONE.
  - Run and SW are ignored during ITER; SW changes do not affect D.
- Latency: Run accepted at edge N; final A/B valid after edge N+WIDTH (8). Done=1 from edge N+WIDTH.
- Aval/Bval show intermediate values during ITER.
- DONE:
  - Hold A, B, X.
  - Stay while Run low (no auto-restart). Run high -> IDLE, Done<=0 at that edge.
- Chaining: a new Run from IDLE without reset divides the current quotient (B) by the new SW; A is cleared at start.
- Invariant for nonzero D: B_final*D + A_final == dividend, and A_final < D.
- HEX outputs are combinational from the A/B registers; standard hex-digit table, segment active-low, 0-F all defined.
- Reset and Run asserted on the same edge: reset wins.

Test Plan:
- Reset low with SW=0xC5, release; Run low with SW=0x07 -> after 8 clocks Bval=0x1C, Aval=0x01, Xval=0, Done=1; HEX3/HEX2 show "1C", HEX1/HEX0 show "01".
- Load 0xFF, divide by 0x01 -> Bval=0xFF, Aval=0x00 at 8 clocks after start; Done low for first 7 clocks.
- Load 0x07, divide by 0xC8 -> Bval=0x00, Aval=0x07; then chain: Run released, then pressed with SW=0x03 -> Bval=0x00, Aval=0x00.
- Load 0x2A, Run with SW=0x00 -> next edge Xval=1, Bval=0xFF, Aval=0x2A, Done=1; subsequent reset clears Xval to 0.
- Reset asserted at iteration 4 with SW=0x10 -> next edge Aval=0, Bval=0x10, Done=0, IDLE; then Run with SW=0x04 -> Bval=0x04, Aval=0.
- Run held low 20 clocks after Done -> registers unchanged, no restart; Run high -> Done=0 next edge. Random sweep of 1000 pairs checks the Q*D+R invariant.
